// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key mapper: scan-code constants, prefix FSM
// states and sizing helpers used by the mapper and its event queue.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_H     = 8'h33;
  localparam logic [7:0] PS2_S     = 8'h1B;
  localparam logic [7:0] PS2_D     = 8'h23;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  // Key-index width; a single bound key still needs one bit.
  function automatic int idx_width(input int num_keys);
    return (num_keys > 1) ? $clog2(num_keys) : 1;
  endfunction

  // Event record is {break, key index}.
  function automatic int evt_width(input int idx_w);
    return idx_w + 1;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO. A push while full is accepted only when a pop
// frees a slot in the same cycle; a pop while empty is ignored.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_mapper.sv
// PS/2 scan-code decoder: prefix FSM, key matcher, held/press state and a
// buffered press/release event queue for game control logic.
module ps2_key_mapper
  import ps2_pkg::*;
#(
  parameter int                    NUM_KEYS       = 3,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = {PS2_D, PS2_S, PS2_H},
  parameter logic [NUM_KEYS-1:0]   EXT_MASK       = '0,
  parameter int                    FIFO_DEPTH     = 4,
  parameter int                    TIMEOUT_CYCLES = 100000,
  localparam int                   IDX_W          = idx_width(NUM_KEYS)
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [7:0]          ps2_data,
  input  logic                ps2_data_en,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                evt_valid,
  output logic [IDX_W-1:0]    evt_key,
  output logic                evt_break,
  input  logic                evt_ready,
  output logic                evt_overflow,
  output logic [7:0]          last_code,
  output logic [1:0]          dbg_state
);

  // Handshake: an event transfers on any rising edge where evt_valid and
  // evt_ready are both high; the head stays stable until it transfers.

  localparam int EVT_W = evt_width(IDX_W);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e          state;
  logic [CNT_W-1:0]    idle_cnt;
  logic                is_ext;
  logic                is_brk;
  logic                final_byte;
  logic                ext_seq;
  logic                brk_seq;
  logic [NUM_KEYS-1:0] hit_oh;
  logic [IDX_W-1:0]    hit_idx;
  logic                hit_any;
  logic                hit_held;
  logic                evt_push;
  logic                evt_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [EVT_W-1:0]    push_data;
  logic [EVT_W-1:0]    head_data;

  assign is_ext     = (ps2_data == PS2_EXT);
  assign is_brk     = (ps2_data == PS2_BREAK);
  assign final_byte = ps2_data_en && !is_ext && !is_brk;
  assign ext_seq    = (state == ST_EXT) || (state == ST_EXT_BRK);
  assign brk_seq    = (state == ST_BRK) || (state == ST_EXT_BRK);

  // Scan from the top index down so the lowest matching key wins.
  always_comb begin
    hit_oh  = '0;
    hit_idx = '0;
    hit_any = 1'b0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (ps2_data == KEY_CODES[8*i +: 8] && ext_seq == EXT_MASK[i]) begin
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
        hit_idx   = IDX_W'(i);
        hit_any   = 1'b1;
      end
    end
  end

  // Repeated makes of a held key and breaks of a released key are dropped.
  assign hit_held  = |(hit_oh & key_held);
  assign evt_push  = final_byte && hit_any && (brk_seq ? hit_held : !hit_held);
  assign push_data = {brk_seq, hit_idx};
  assign evt_pop   = evt_ready && !fifo_empty;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      idle_cnt <= '0;
    end else if (ps2_data_en) begin
      idle_cnt <= '0;
      case (state)
        ST_IDLE: begin
          if (is_ext)      state <= ST_EXT;
          else if (is_brk) state <= ST_BRK;
          else             state <= ST_IDLE;
        end
        ST_EXT: begin
          if (is_brk)      state <= ST_EXT_BRK;
          else if (is_ext) state <= ST_EXT;
          else             state <= ST_IDLE;
        end
        ST_BRK: begin
          if (!is_ext && !is_brk) state <= ST_IDLE;
        end
        ST_EXT_BRK: begin
          if (!is_ext && !is_brk) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      // A stalled partial sequence is abandoned without producing an event.
      if (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state    <= ST_IDLE;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end else begin
      idle_cnt <= '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      key_press    <= '0;
      key_held     <= '0;
      last_code    <= '0;
      evt_overflow <= 1'b0;
    end else begin
      key_press <= '0;
      if (final_byte) begin
        last_code <= ps2_data;
        if (hit_any) begin
          if (brk_seq) begin
            if (hit_held) key_held <= key_held & ~hit_oh;
          end else if (!hit_held) begin
            key_held  <= key_held | hit_oh;
            key_press <= hit_oh;
          end
        end
      end
      if (evt_push && fifo_full && !evt_pop) begin
        evt_overflow <= 1'b1;
      end
    end
  end

  ps2_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .push      (evt_push),
    .push_data (push_data),
    .pop       (evt_ready),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign evt_valid            = !fifo_empty;
  assign {evt_break, evt_key} = head_data;
  assign dbg_state            = state;

endmodule

// File: tb/tb_ps2_key_mapper.sv
// Bench for ps2_key_mapper: a default-key instance and an E0-extended-key
// instance, each with an event scoreboard.
module tb_ps2_key_mapper;

  logic       clk;
  int         checks;
  int         errors;

  // Instance A: default H/S/D keys, short timeout.
  logic       resetn_a, en_a, ready_a;
  logic [7:0] data_a;
  logic [2:0] press_a, held_a;
  logic       valid_a, brk_a, ovf_a;
  logic [1:0] key_a, state_a;
  logic [7:0] last_a;
  logic [2:0] exp_q_a[$];
  int         press_cnt_a[3];

  // Instance B: key 2 bound to E0 75.
  logic       resetn_b, en_b, ready_b;
  logic [7:0] data_b;
  logic [2:0] press_b, held_b;
  logic       valid_b, brk_b, ovf_b;
  logic [1:0] key_b, state_b;
  logic [7:0] last_b;
  logic [2:0] exp_q_b[$];

  ps2_key_mapper #(
    .TIMEOUT_CYCLES (20)
  ) dut_a (
    .CLOCK_50 (clk), .resetn (resetn_a), .ps2_data (data_a), .ps2_data_en (en_a),
    .key_press (press_a), .key_held (held_a), .evt_valid (valid_a), .evt_key (key_a),
    .evt_break (brk_a), .evt_ready (ready_a), .evt_overflow (ovf_a),
    .last_code (last_a), .dbg_state (state_a)
  );

  ps2_key_mapper #(
    .KEY_CODES      ({8'h75, 8'h1B, 8'h33}),
    .EXT_MASK       (3'b100),
    .TIMEOUT_CYCLES (20)
  ) dut_b (
    .CLOCK_50 (clk), .resetn (resetn_b), .ps2_data (data_b), .ps2_data_en (en_b),
    .key_press (press_b), .key_held (held_b), .evt_valid (valid_b), .evt_key (key_b),
    .evt_break (brk_b), .evt_ready (ready_b), .evt_overflow (ovf_b),
    .last_code (last_b), .dbg_state (state_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drivers: strobe held for exactly one edge; back-to-back calls give
  // strobes on consecutive cycles.
  task automatic send_a(input logic [7:0] b);
    data_a = b;
    en_a   = 1'b1;
    @(posedge clk);
    #1;
    en_a   = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    data_b = b;
    en_b   = 1'b1;
    @(posedge clk);
    #1;
    en_b   = 1'b0;
  endtask

  // Scoreboard monitors: compare the head at every accepted transfer.
  always @(negedge clk) begin
    if (valid_a && ready_a) begin
      checks++;
      if (exp_q_a.size() == 0) begin
        errors++;
        $display("FAIL evt_a: got unexpected event %0h expected none", {brk_a, key_a});
      end else begin
        logic [2:0] e;
        e = exp_q_a.pop_front();
        if ({brk_a, key_a} !== e) begin
          errors++;
          $display("FAIL evt_a: got %0h expected %0h", {brk_a, key_a}, e);
        end
      end
    end
    for (int i = 0; i < 3; i++) press_cnt_a[i] = press_cnt_a[i] + int'(press_a[i]);
  end

  always @(negedge clk) begin
    if (valid_b && ready_b) begin
      checks++;
      if (exp_q_b.size() == 0) begin
        errors++;
        $display("FAIL evt_b: got unexpected event %0h expected none", {brk_b, key_b});
      end else begin
        logic [2:0] e;
        e = exp_q_b.pop_front();
        if ({brk_b, key_b} !== e) begin
          errors++;
          $display("FAIL evt_b: got %0h expected %0h", {brk_b, key_b}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    checks = 0; errors = 0;
    resetn_a = 1'b0; resetn_b = 1'b0;
    en_a = 1'b0; en_b = 1'b0; data_a = '0; data_b = '0;
    ready_a = 1'b1; ready_b = 1'b1;
    idle(3);
    check("rst_held", held_a, 3'b000);
    check("rst_press", press_a, 3'b000);
    check("rst_valid", valid_a, 1'b0);
    check("rst_ovf", ovf_a, 1'b0);
    check("rst_last", last_a, 8'h00);
    check("rst_state", state_a, 2'd0);
    resetn_a = 1'b1; resetn_b = 1'b1;
    idle(2);

    // H make, break
    exp_q_a.push_back(3'b000);
    send_a(8'h33);
    check("h_press_lat1", press_a, 3'b001);
    check("h_held_set", held_a, 3'b001);
    exp_q_a.push_back(3'b100);
    send_a(8'hF0);
    send_a(8'h33);
    check("h_held_clr", held_a, 3'b000);
    check("h_no_press_on_break", press_a, 3'b000);
    check("h_last_code", last_a, 8'h33);
    idle(3);

    // S typematic repeat
    p0 = press_cnt_a[1];
    exp_q_a.push_back(3'b001);
    exp_q_a.push_back(3'b101);
    repeat (5) send_a(8'h1B);
    check("s_held_repeat", held_a, 3'b010);
    send_a(8'hF0);
    send_a(8'h1B);
    idle(3);
    check("s_one_pulse", press_cnt_a[1] - p0, 1);
    check("s_released", held_a, 3'b000);

    // Timeout out of BRK, boundary at TIMEOUT_CYCLES
    send_a(8'hF0);
    check("to_in_brk", state_a, 2'd2);
    idle(19);
    check("to_before_limit", state_a, 2'd2);
    idle(1);
    check("to_at_limit", state_a, 2'd0);
    exp_q_a.push_back(3'b010);
    send_a(8'h23);
    check("to_d_make", press_a, 3'b100);
    exp_q_a.push_back(3'b110);
    send_a(8'hF0);
    send_a(8'h23);
    idle(3);
    check("to_d_release", held_a, 3'b000);

    // Overflow with consumer stalled
    ready_a = 1'b0;
    exp_q_a.push_back(3'b000);
    exp_q_a.push_back(3'b001);
    exp_q_a.push_back(3'b010);
    exp_q_a.push_back(3'b100);
    send_a(8'h33); send_a(8'h1B); send_a(8'h23);
    send_a(8'hF0); send_a(8'h33);
    check("ovf_full_no_ovf", ovf_a, 1'b0);
    send_a(8'hF0); send_a(8'h1B);
    check("ovf_set", ovf_a, 1'b1);
    send_a(8'hF0); send_a(8'h23);
    check("ovf_head_key", key_a, 2'd0);
    check("ovf_head_brk", brk_a, 1'b0);
    ready_a = 1'b1;
    idle(6);
    check("ovf_drained", valid_a, 1'b0);
    check("ovf_sticky", ovf_a, 1'b1);
    resetn_a = 1'b0;
    idle(1);
    check("ovf_rst_clear", ovf_a, 1'b0);
    resetn_a = 1'b1;
    idle(2);

    // Push and pop on the same edge while full
    ready_a = 1'b0;
    exp_q_a.push_back(3'b000);
    exp_q_a.push_back(3'b001);
    exp_q_a.push_back(3'b010);
    exp_q_a.push_back(3'b100);
    exp_q_a.push_back(3'b101);
    send_a(8'h33); send_a(8'h1B); send_a(8'h23);
    send_a(8'hF0); send_a(8'h33);
    send_a(8'hF0);
    ready_a = 1'b1;
    send_a(8'h1B);
    check("pp_full_no_ovf", ovf_a, 1'b0);
    idle(8);
    check("pp_drained", valid_a, 1'b0);
    exp_q_a.push_back(3'b110);
    send_a(8'hF0); send_a(8'h23);
    idle(3);

    // Extended key on instance B
    exp_q_b.push_back(3'b010);
    send_b(8'hE0);
    check("ext_state", state_b, 2'd1);
    send_b(8'h75);
    check("ext_press", press_b, 3'b100);
    send_b(8'h75);
    check("bare_no_press", press_b, 3'b000);
    check("bare_last_code", last_b, 8'h75);
    check("bare_held_kept", held_b, 3'b100);
    exp_q_b.push_back(3'b110);
    send_b(8'hE0); send_b(8'hF0);
    check("ext_brk_state", state_b, 2'd3);
    send_b(8'h75);
    check("ext_release", held_b, 3'b000);
    idle(3);

    // Asynchronous reset mid-sequence and mid-queue
    ready_b = 1'b0;
    send_b(8'h33);
    send_b(8'hE0);
    idle(1);
    check("mid_queued", valid_b, 1'b1);
    #2;
    resetn_b = 1'b0;
    exp_q_b.delete();
    #1;
    check("async_held", held_b, 3'b000);
    check("async_valid", valid_b, 1'b0);
    check("async_last", last_b, 8'h00);
    check("async_state", state_b, 2'd0);
    idle(2);
    resetn_b = 1'b1;
    ready_b  = 1'b1;
    idle(2);
    send_b(8'h75);
    check("post_rst_no_press", press_b, 3'b000);
    check("post_rst_last", last_b, 8'h75);
    idle(2);
    check("post_rst_no_evt", valid_b, 1'b0);

    idle(5);
    check("exp_q_a_empty", exp_q_a.size(), 0);
    check("exp_q_b_empty", exp_q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_mapper.md
# ps2_key_mapper

- Parametrised PS/2 scan-code decoder. Sits between `PS2_Controller` (byte stream) and game control logic.
- Maps up to NUM_KEYS configurable make codes to per-key outputs:
  - one-cycle press pulses,
  - held levels,
  - a buffered press/release event queue with valid/ready handshake.
- Adds E0-extended keys, typematic-repeat suppression, release events, stall timeout and overflow reporting. Generalises the fixed H/S/D hit/stand/deal decoder.

## Interface
- NUM_KEYS, 3: number of bound keys, 1..16.
- KEY_CODES, {8'h23,8'h1B,8'h33}: NUM_KEYS×8 packed codes. Key i at bits [8i+7:8i]. Defaults: 0 = H (hit), 1 = S (stand), 2 = D (deal).
- EXT_MASK, 3'b000: bit i set means key i requires the E0 prefix.
- FIFO_DEPTH, 4: event queue depth. Power of two, ≥2.
- TIMEOUT_CYCLES, 100000: idle cycles (2 ms at 50 MHz) before a partial sequence is abandoned.
- IDX_W, derived: max(1, clog2(NUM_KEYS)).
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ps2_data  in  8  received byte from PS2_Controller.
- ps2_data_en  in  1  one-cycle strobe; ps2_data valid this cycle.
- key_press  out  NUM_KEYS  one-cycle pulse on first make of key i.
- key_held  out  NUM_KEYS  level; key i currently down.
- evt_valid  out  1  event queue non-empty.
- evt_key  out  IDX_W  key index of head event.
- evt_break  out  1  head event is a release (1) or press (0).
- evt_ready  in  1  consumer accepts head when evt_valid && evt_ready.
- evt_overflow  out  1  sticky; an event was dropped because the queue was full.
- last_code  out  8  last non-prefix byte received (debug LEDs).

## Operation
- Prefix FSM with states IDLE, EXT, BRK, EXT_BRK. A byte is processed only when ps2_data_en = 1.
  - IDLE: E0 → EXT; F0 → BRK; other byte → make(code, ext=0).
  - EXT: F0 → EXT_BRK; E0 → stay; other byte → make(code, ext=1), then IDLE.
  - BRK: E0/F0 → stay; other byte → break(code, 0), then IDLE.
  - EXT_BRK: E0/F0 → stay; other byte → break(code, 1), then IDLE.
- Timeout: any non-IDLE state with no ps2_data_en for TIMEOUT_CYCLES consecutive cycles → IDLE. No event is produced. The counter clears on every strobe.
- Match rule: key i matches when code == KEY_CODES[i] and ext == EXT_MASK[i]. If several keys match, the lowest index wins. Unmatched codes only update last_code.
- Make on key i:
  - If key_held[i] = 0: set key_held[i], pulse key_press[i], push {break=0, i}.
  - If key_held[i] = 1: typematic repeat. No pulse, no push.
- Break on key i:
  - If key_held[i] = 1: clear it and push {break=1, i}.
  - Otherwise ignored.
- Queue behaviour:
  - FIFO order.
  - Push when full: event dropped, evt_overflow ← 1 until reset.
  - Push and pop in the same cycle while full: push accepted, no overflow.
  - Pop when empty: ignored.
- Reset values: all outputs 0; FSM in IDLE; queue empty; timeout counter 0.

## Timing
- key_press / key_held / last_code update in the cycle after the strobe carrying the final byte (latency 1).
- evt_valid rises in the cycle after the push. evt_key / evt_break are stable while evt_valid && !evt_ready.
- Strobes on consecutive cycles are fully supported; no byte is lost.
- resetn assertion mid-sequence or mid-queue clears everything immediately, asynchronously. Deassertion is synchronised externally.

## Structure
- Shared package `ps2_pkg`:
  - scan-code constants PS2_EXT = 8'hE0, PS2_BREAK = 8'hF0, PS2_H/S/D;
  - the FSM state enum;
  - event record width (IDX_W+1).
- Sub-module `ps2_evt_fifo`: parametrised synchronous FIFO with push/pop, full/empty and a same-cycle push-pop-when-full rule.
- Matcher and FSM live in the top.

## Test plan
- Bytes 33, F0, 33 (defaults) → key_press[0] pulse one cycle after the first 33. key_held[0] 1 → 0. Queue pops {0,0} then {1,0}.
- Bytes 1B ×5 then F0 1B → exactly one key_press[1] pulse. Queue holds exactly two events: {0,1} then {1,1}.
- EXT_MASK = 3'b100, KEY_CODES[2] = 75:
  - E0 75 → press of key 2;
  - bare 75 → no effect, last_code = 75;
  - E0 F0 75 → release of key 2.
- Bytes F0 then 150000 idle cycles then 23 → state returns to IDLE at timeout. 23 is treated as a make: key_press[2] fires.
- FIFO_DEPTH = 4, evt_ready = 0, six distinct press/release events → four queued, evt_overflow = 1. The cycle with the fifth push and a simultaneous pop does not set overflow.
- resetn low between E0 and 75 → all outputs 0 and queue empty. A following 75 is decoded as non-extended.
